player_motion: RTL
==================

PLAYER_MOTION -- requirements
Module: player_motion

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- START_X, 8, x after reset.
- GROUND_Y, 100, resting y (4x4 sprite bottom row at 103).
- JUMP_H, 20, pixels risen per jump.
- HANG_TICKS, 4, frame ticks held at apex.
- X_MAX, 159, last screen column.
REQ-002 Ports, one per line: name, direction, width, meaning.
- clock, in, 1, system clock.
- resetn, in, 1, reset (synchronous, active-low).
- frame_tick, in, 1, one-cycle pulse per frame.
- jump, in, 1, jump button level, already synchronised.
- collided, in, 1, from the downstream collision stage.
- reached_screen_end, in, 1, from the downstream collision stage.
- x_c, out, 8, current sprite top-left x.
- y_c, out, 7, current sprite top-left y.
- old_x, out, 8, x before the last update, used for erase.
- old_y, out, 7, y before the last update, used for erase.
- update, out, 1, one-cycle pulse when the position changed.
- state_o, out, 3, encoded FSM state.

Function
REQ-003 FSM states SHALL be RUN, RISE, HANG, FALL and STOP; the encoding SHALL be exported on state_o.
REQ-004 Jump request: the block SHALL detect a rising edge of jump and latch it until the next frame_tick, where it is consumed. A held level SHALL NOT retrigger.
REQ-005 All motion SHALL occur only on the cycle where frame_tick=1. Outputs SHALL be registered, with 1-cycle latency from frame_tick.
REQ-006 On every tick outside STOP, x_c SHALL increment by 1, saturating at X_MAX.
REQ-007 RUN: y_c = GROUND_Y. A latched request SHALL cause RUN->RISE on that tick, and apex_y SHALL be set to GROUND_Y-JUMP_H.
REQ-008 RISE: y_c SHALL decrement by 1 per tick. When the new y_c equals apex_y, the FSM SHALL go RISE->HANG and the hang counter SHALL be cleared.
REQ-009 HANG: y_c SHALL be unchanged. The FSM SHALL go HANG->FALL after HANG_TICKS ticks.
REQ-010 FALL: y_c SHALL increment by 1 per tick. When the new y_c equals GROUND_Y, the FSM SHALL go FALL->RUN.
REQ-011 Jump requests arriving outside RUN SHALL be discarded (see REQ-019 for the exception).
REQ-012 collided or reached_screen_end sampled high on any cycle SHALL force STOP on the next edge. STOP SHALL be terminal until reset.
REQ-013 STOP takes priority: if a stop condition and frame_tick occur in the same cycle, the FSM SHALL enter STOP with no position change and no update pulse.
REQ-014 update SHALL pulse exactly one cycle after a tick that changed x_c or y_c.
REQ-015 old_x and old_y SHALL capture the pre-change values on that same edge.
REQ-016 No update pulse SHALL be issued while x is saturated and y is unchanged.
REQ-017 All y arithmetic SHALL be 7-bit unsigned, and y_c SHALL never go below 0.

Reset
REQ-018 When resetn=0 at a clock edge:
- state SHALL be RUN;
- x_c and old_x SHALL be START_X;
- y_c and old_y SHALL be GROUND_Y;
- update SHALL be 0;
- the jump latch, the edge register and the hang counter SHALL be cleared;
- these values SHALL hold regardless of the other inputs, including a reset asserted mid-jump.

Configuration
REQ-019 Macro PLAYER_MOTION_DOUBLE_JUMP_EN:
- Defined: one extra jump edge SHALL be accepted in RISE, HANG or FALL. It SHALL enter RISE with apex_y = max(y_c-JUMP_H, 0). The used flag SHALL be cleared on landing (FALL->RUN) and on reset.
- Undefined: REQ-011 applies strictly, and the flag logic SHALL be absent.

Structure
REQ-020 Package player_pkg SHALL hold the state enum, the coordinate widths, and the defaults for GROUND_Y, START_X and X_MAX.
REQ-021 Jump edge-detect plus the request latch SHALL be one sub-module, jump_edge_latch.

Verification
REQ-022 Reset then 5 ticks, no jump -> x_c 8->13, y_c=100, five update pulses.
REQ-023 Jump edge then ticks -> y_c 99..80 over 20 ticks, then 80 held for 4 ticks, then 81..100 over 20 ticks, then RUN; x_c +44 in total.
REQ-024 jump held high through a full jump -> exactly one jump, and no retrigger on landing.
REQ-025 collided=1 coincident with frame_tick at x_c=40 -> STOP, x_c stays 40, no update pulse; further ticks ignored until resetn=0.
REQ-026 x_c reaches 159 -> stays 159; reached_screen_end=1 -> STOP.
REQ-027 With PLAYER_MOTION_DOUBLE_JUMP_EN defined, a second edge at y_c=85 -> new apex 65. A third edge SHALL be ignored until landing.

Source files
------------

// File: rtl/player_pkg.sv
// player_pkg -- shared definitions for the player motion block.
//   state_t        : FSM state encoding, exported on player_motion.state_o
//   X_W / Y_W      : coordinate widths (x 8-bit, y 7-bit unsigned)
//   *_DEF          : default START_X, GROUND_Y, X_MAX
//   apex_from()    : saturating apex computation, never below row 0
package player_pkg;

    localparam int X_W = 8;
    localparam int Y_W = 7;

    localparam int START_X_DEF  = 8;
    localparam int GROUND_Y_DEF = 100;
    localparam int X_MAX_DEF    = 159;

    typedef enum logic [2:0] {
        RUN  = 3'd0,
        RISE = 3'd1,
        HANG = 3'd2,
        FALL = 3'd3,
        STOP = 3'd4
    } state_t;

    // Apex row for a jump started at row y: y - h, clamped at 0.
    function automatic logic [Y_W-1:0] apex_from(input logic [Y_W-1:0] y,
                                                 input logic [Y_W-1:0] h);
        if (y > h) begin
            return y - h;
        end else begin
            return 7'd0;
        end
    endfunction

endpackage

// File: rtl/player_motion_jump_edge_latch.sv
// jump_edge_latch -- rising-edge detect on the jump button plus a request
// latch that holds the request until the next frame tick consumes it.
// An edge arriving on a tick cycle survives to the following tick.
//   clock, resetn : clock and synchronous active-low reset
//   jump          : synchronised button level
//   frame_tick    : one-cycle pulse per frame (consumes the request)
//   req           : registered pending jump request
module jump_edge_latch (
    input  logic clock,
    input  logic resetn,
    input  logic jump,
    input  logic frame_tick,
    output logic req
);

    logic jump_d_r;
    logic edge_s;

    assign edge_s = jump & ~jump_d_r;

    // Edge register and request latch; a held level never sets req again.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            jump_d_r <= 1'b0;
            req      <= 1'b0;
        end else begin
            jump_d_r <= jump;
            req      <= edge_s | (req & ~frame_tick);
        end
    end

endmodule

// File: rtl/player_motion.sv
// player_motion -- sprite position FSM (RUN/RISE/HANG/FALL/STOP).
// Motion happens only on frame_tick; all outputs are registered.
// Optional feature macro: PLAYER_MOTION_DOUBLE_JUMP_EN (one mid-air jump
// allowed until landing).
// Ports:
//   clock, resetn            : clock, synchronous active-low reset
//   frame_tick               : one-cycle pulse per frame
//   jump                     : jump button level (synchronised)
//   collided,
//   reached_screen_end       : stop conditions, force terminal STOP
//   x_c, y_c                 : current sprite top-left position
//   old_x, old_y             : position before the last change (erase)
//   update                   : one-cycle pulse after a position change
//   state_o                  : encoded FSM state (player_pkg::state_t)
module player_motion
    import player_pkg::*;
#(
    parameter int START_X    = START_X_DEF,
    parameter int GROUND_Y   = GROUND_Y_DEF,
    parameter int JUMP_H     = 20,
    parameter int HANG_TICKS = 4,
    parameter int X_MAX      = X_MAX_DEF
) (
    input  logic           clock,
    input  logic           resetn,
    input  logic           frame_tick,
    input  logic           jump,
    input  logic           collided,
    input  logic           reached_screen_end,
    output logic [X_W-1:0] x_c,
    output logic [Y_W-1:0] y_c,
    output logic [X_W-1:0] old_x,
    output logic [Y_W-1:0] old_y,
    output logic           update,
    output logic [2:0]     state_o
);

    localparam logic [X_W-1:0] START_X_C   = X_W'(START_X);
    localparam logic [X_W-1:0] X_MAX_C     = X_W'(X_MAX);
    localparam logic [Y_W-1:0] GROUND_C    = Y_W'(GROUND_Y);
    localparam logic [Y_W-1:0] JUMP_C      = Y_W'(JUMP_H);
    localparam logic [7:0]     HANG_LAST_C = 8'(HANG_TICKS - 1);

    state_t         state_r;
    logic [Y_W-1:0] apex_r;
    logic [7:0]     hang_cnt_r;
    logic           req_s;
    logic           stop_s;
    logic           start_jump_s;
    logic [X_W-1:0] x_next_s;
    logic [Y_W-1:0] y_dec_s;
    logic [Y_W-1:0] y_new_s;
    logic [Y_W-1:0] jump_apex_s;
`ifdef PLAYER_MOTION_DOUBLE_JUMP_EN
    logic           dbl_used_r;
`endif

    jump_edge_latch u_jump_edge_latch (
        .clock      (clock),
        .resetn     (resetn),
        .jump       (jump),
        .frame_tick (frame_tick),
        .req        (req_s)
    );

    assign stop_s  = collided | reached_screen_end;
    assign state_o = state_r;

    // Next-position arithmetic and jump-start decision for the current state.
    always_comb begin
        x_next_s     = x_c;
        y_dec_s      = y_c;
        y_new_s      = y_c;
        jump_apex_s  = apex_from(GROUND_C, JUMP_C);
        start_jump_s = 1'b0;

        if (x_c < X_MAX_C) begin
            x_next_s = x_c + 8'd1;
        end else begin
            x_next_s = x_c;
        end

        if (y_c != 7'd0) begin
            y_dec_s = y_c - 7'd1;
        end else begin
            y_dec_s = 7'd0;
        end

        if (state_r == RUN) begin
            jump_apex_s = apex_from(GROUND_C, JUMP_C);
        end else begin
            jump_apex_s = apex_from(y_c, JUMP_C);
        end

`ifdef PLAYER_MOTION_DOUBLE_JUMP_EN
        start_jump_s = req_s & ((state_r == RUN) |
                       (~dbl_used_r & ((state_r == RISE) | (state_r == HANG) |
                                       (state_r == FALL))));
`else
        start_jump_s = req_s & (state_r == RUN);
`endif

        if (start_jump_s) begin
            y_new_s = y_dec_s;
        end else begin
            case (state_r)
                RISE:    y_new_s = y_dec_s;
                FALL:    y_new_s = y_c + 7'd1;
                default: y_new_s = y_c;
            endcase
        end
    end

    // FSM with registered position, erase copy and update pulse.
    // Stop conditions win over a coincident tick; STOP holds until reset.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_r    <= RUN;
            x_c        <= START_X_C;
            old_x      <= START_X_C;
            y_c        <= GROUND_C;
            old_y      <= GROUND_C;
            update     <= 1'b0;
            apex_r     <= apex_from(GROUND_C, JUMP_C);
            hang_cnt_r <= 8'd0;
`ifdef PLAYER_MOTION_DOUBLE_JUMP_EN
            dbl_used_r <= 1'b0;
`endif
        end else if (state_r == STOP) begin
            update <= 1'b0;
        end else if (stop_s) begin
            state_r <= STOP;
            update  <= 1'b0;
        end else if (frame_tick) begin
            if ((x_next_s != x_c) || (y_new_s != y_c)) begin
                update <= 1'b1;
                old_x  <= x_c;
                old_y  <= y_c;
            end else begin
                update <= 1'b0;
            end
            x_c <= x_next_s;
            y_c <= y_new_s;

            if (start_jump_s) begin
                apex_r     <= jump_apex_s;
                hang_cnt_r <= 8'd0;
                // A jump of height 1 reaches its apex on the starting tick.
                state_r    <= (y_new_s == jump_apex_s) ? HANG : RISE;
`ifdef PLAYER_MOTION_DOUBLE_JUMP_EN
                if (state_r != RUN) begin
                    dbl_used_r <= 1'b1;
                end
`endif
            end else begin
                case (state_r)
                    RISE: begin
                        if (y_new_s == apex_r) begin
                            state_r    <= HANG;
                            hang_cnt_r <= 8'd0;
                        end
                    end
                    HANG: begin
                        if (hang_cnt_r == HANG_LAST_C) begin
                            state_r <= FALL;
                        end else begin
                            hang_cnt_r <= hang_cnt_r + 8'd1;
                        end
                    end
                    FALL: begin
                        if (y_new_s == GROUND_C) begin
                            state_r <= RUN;
`ifdef PLAYER_MOTION_DOUBLE_JUMP_EN
                            dbl_used_r <= 1'b0;
`endif
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end else begin
            update <= 1'b0;
        end
    end

endmodule
